// File: rtl/move_input_conditioner.sv
// Button front end for the 2048 game FSM: synchronise, debounce, reject chords, one move per press.
// Optional build macro AUTO_REPEAT_EN re-issues the held direction every REPEAT_CYCLES while in HOLD.
module move_input_conditioner #(
    parameter int DB_CYCLES     = 1000000,
    parameter int REPEAT_CYCLES = 40000000,
    parameter int CNT_W         = 26
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       move_ready,
    output logic       move_valid,
    output logic [1:0] move_dir,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DEBOUNCE = 3'd1,
        VALID    = 3'd2,
        HOLD     = 3'd3,
        RELEASE  = 3'd4
    } state_t;

    localparam int CNT_LIMIT = (DB_CYCLES > REPEAT_CYCLES) ? DB_CYCLES : REPEAT_CYCLES;
    localparam logic [CNT_W-1:0] CNT_CAP = CNT_W'(CNT_LIMIT - 1);
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);
`ifdef AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);
`endif

    state_t           state, stateNext;
    logic [CNT_W-1:0] cnt, cntNext;
    logic [1:0]       dir, dirNext;
    logic [3:0]       btnSync_p0, btnSync_p1;
    logic [3:0]       s;

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
        return (v >= CNT_CAP) ? CNT_CAP : v + CNT_W'(1);
    endfunction

    function automatic logic [3:0] dirMask(input logic [1:0] d);
        case (d)
            2'b00:   return 4'b1000;
            2'b01:   return 4'b0100;
            2'b10:   return 4'b0010;
            default: return 4'b0001;
        endcase
    endfunction

    function automatic logic [1:0] encodeDir(input logic [3:0] v);
        case (v)
            4'b1000: return 2'b00;
            4'b0100: return 2'b01;
            4'b0010: return 2'b10;
            default: return 2'b11;
        endcase
    endfunction

    // Stage p0/p1: two-flop synchroniser, s = {up, down, left, right}
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            btnSync_p0 <= 4'b0000;
            btnSync_p1 <= 4'b0000;
        end else begin
            btnSync_p0 <= {btn_up, btn_down, btn_left, btn_right};
            btnSync_p1 <= btnSync_p0;
        end
    end

    assign s = btnSync_p1;

    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        dirNext   = dir;
        case (state)
            IDLE: begin
                if ($onehot(s)) begin
                    dirNext   = encodeDir(s);
                    cntNext   = '0;
                    stateNext = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (s != dirMask(dir)) begin
                    cntNext   = '0;
                    stateNext = IDLE;
                end else if (cnt == DB_LAST) begin
                    stateNext = VALID;
                end else begin
                    cntNext = satInc(cnt);
                end
            end
            VALID: begin
                // Buttons are deliberately ignored here; only the handshake leaves VALID.
                if (move_valid && move_ready) begin
                    cntNext   = '0;
                    stateNext = HOLD;
                end
            end
            HOLD: begin
                if (s == 4'b0000) begin
                    cntNext   = '0;
                    stateNext = RELEASE;
                end
`ifdef AUTO_REPEAT_EN
                else if (s == dirMask(dir)) begin
                    if (cnt == REP_LAST) begin
                        stateNext = VALID;
                    end else begin
                        cntNext = satInc(cnt);
                    end
                end else begin
                    cntNext = '0;
                end
`endif
            end
            RELEASE: begin
                if (s != 4'b0000) begin
                    cntNext   = '0;
                    stateNext = HOLD;
                end else if (cnt == DB_LAST) begin
                    stateNext = IDLE;
                end else begin
                    cntNext = satInc(cnt);
                end
            end
            default: begin
                cntNext   = '0;
                stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            dir        <= 2'b00;
            move_valid <= 1'b0;
        end else begin
            state      <= stateNext;
            cnt        <= cntNext;
            dir        <= dirNext;
            move_valid <= (stateNext == VALID);
        end
    end

    assign move_dir = dir;
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_move_input_conditioner.sv
// Scoreboard bench for move_input_conditioner with DB_CYCLES=4, REPEAT_CYCLES=16.
module tb_move_input_conditioner;

    localparam int DB  = 4;
    localparam int REP = 16;
    localparam int LAT = 2 + 1 + DB;

    logic       Clk;
    logic       Reset_n;
    logic       btn_up, btn_down, btn_left, btn_right;
    logic       move_ready;
    logic       move_valid;
    logic [1:0] move_dir;
    logic       busy;

    typedef struct {
        logic [1:0] dir;
        int         cyc;
    } exp_t;

    exp_t expQ[$];
    int   cyc       = 0;
    int   passCnt   = 0;
    int   totalCnt  = 0;

    move_input_conditioner #(
        .DB_CYCLES(DB),
        .REPEAT_CYCLES(REP),
        .CNT_W(26)
    ) dut (
        .Clk(Clk),
        .Reset_n(Reset_n),
        .btn_up(btn_up),
        .btn_down(btn_down),
        .btn_left(btn_left),
        .btn_right(btn_right),
        .move_ready(move_ready),
        .move_valid(move_valid),
        .move_dir(move_dir),
        .busy(busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        totalCnt++;
        if (act === req) begin
            passCnt++;
        end else begin
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic expectMove(input logic [1:0] d, input int c);
        exp_t e;
        e.dir = d;
        e.cyc = c;
        expQ.push_back(e);
    endtask

    // Monitor: every accepted move must match the head of the scoreboard
    always @(negedge Clk) begin
        if (Reset_n && move_valid && move_ready) begin
            check("move_expected", 32'(expQ.size() > 0), 1);
            if (expQ.size() > 0) begin
                exp_t e;
                e = expQ.pop_front();
                check("move_dir", 32'(move_dir), 32'(e.dir));
                check("move_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        Reset_n    = 1'b0;
        btn_up     = 1'b0;
        btn_down   = 1'b0;
        btn_left   = 1'b0;
        btn_right  = 1'b0;
        move_ready = 1'b0;
        step(3);
        check("reset_valid", 32'(move_valid), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_dir", 32'(move_dir), 0);
        Reset_n = 1'b1;
        step(3);
        check("idle_busy", 32'(busy), 0);

        // 1: single press, ready high
        move_ready = 1'b1;
        btn_up = 1'b1;
        expectMove(2'b00, cyc + LAT);
        step(LAT);
        check("t1_valid", 32'(move_valid), 1);
        check("t1_busy", 32'(busy), 1);
        step(1);
        check("t1_valid_drop", 32'(move_valid), 0);
        step(12);
        btn_up = 1'b0;
        step(12);
        check("t1_idle", 32'(busy), 0);

        // 2: consumer stalls for 10 cycles
        move_ready = 1'b0;
        btn_left = 1'b1;
        step(LAT);
        for (int i = 0; i < 10; i++) begin
            check("t2_valid_hold", 32'(move_valid), 1);
            check("t2_dir_hold", 32'(move_dir), 2);
            step(1);
        end
        expectMove(2'b10, cyc);
        move_ready = 1'b1;
        step(1);
        check("t2_valid_drop", 32'(move_valid), 0);
        step(20);
        btn_left = 1'b0;
        step(12);
        btn_left = 1'b1;
        expectMove(2'b10, cyc + LAT);
        step(20);
        btn_left = 1'b0;
        step(12);

        // 3: bouncing right button, then held
        for (int i = 0; i < 10; i++) begin
            btn_right = ~btn_right;
            step(2);
        end
        check("t3_no_move", 32'(move_valid), 0);
        btn_right = 1'b1;
        expectMove(2'b11, cyc + LAT);
        step(20);
        btn_right = 1'b0;
        step(12);

        // 4: chord is rejected, then resolves to a single button
        btn_up = 1'b1;
        btn_down = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step(1);
            if (i % 10 == 9) begin
                check("t4_busy", 32'(busy), 0);
                check("t4_valid", 32'(move_valid), 0);
            end
        end
        btn_down = 1'b0;
        expectMove(2'b00, cyc + LAT);
        step(20);
        btn_up = 1'b0;
        step(12);

        // 5: asynchronous reset while a move is pending
        move_ready = 1'b0;
        btn_right = 1'b1;
        step(LAT);
        check("t5_valid_pending", 32'(move_valid), 1);
        #2;
        Reset_n = 1'b0;
        #1;
        check("t5_async_valid", 32'(move_valid), 0);
        check("t5_async_busy", 32'(busy), 0);
        check("t5_async_dir", 32'(move_dir), 0);
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        move_ready = 1'b1;
        expectMove(2'b11, cyc + LAT);
        step(20);
        btn_right = 1'b0;
        step(12);

        // 6: long hold; repeats only when auto-repeat is built in
        btn_down = 1'b1;
        expectMove(2'b01, cyc + LAT);
`ifdef AUTO_REPEAT_EN
        expectMove(2'b01, cyc + LAT + (REP + 1));
        expectMove(2'b01, cyc + LAT + 2 * (REP + 1));
        expectMove(2'b01, cyc + LAT + 3 * (REP + 1));
`endif
        step(60);
        btn_down = 1'b0;
        step(12);
        check("t6_idle", 32'(busy), 0);

        check("queue_drained", expQ.size(), 0);
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
